mips_avalon_mem_responder: RTL and testbench
============================================

# mips_avalon_mem_responder

Word-addressed memory responder for the CPU's Avalon-style memory port, answering the fetch and load/store requests the core issues from its program-counter and datapath addresses. It decodes a 32-bit byte address into a parameterised window starting at the reset vector, inserts a programmable number of wait states via `waitrequest`, returns registered read data and commits byte-enabled writes. It also provides a backdoor load port so benches can preload programs before releasing reset.

## Interface
- `ADDR_BASE`, default 32'hBFC00000: byte address of word 0 of the window.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, 16 to 65536.
- `WAIT_CYCLES`, default 2: extra stall cycles per transfer; 0 to 15.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `address` input 32: byte address from the CPU.
- `read` input 1: read request.
- `write` input 1: write request.
- `byteenable` input 4: write lane enables; bit n covers `writedata[8n+7:8n]`.
- `writedata` input 32: write data.
- `waitrequest` output 1: high means the request is not yet accepted, so the master holds all inputs.
- `readdata` output 32: read result; valid in the cycle where `read`=1 and `waitrequest`=0.
- `err` output 1: sticky flag for any faulting access; cleared only by reset.
- `load_en` input 1: backdoor write strobe.
- `load_addr` input 32: backdoor byte address, decoded the same way as `address`.
- `load_data` input 32: backdoor word; all four bytes are written.

## Operation
- Decode:
  - In range when `address[1:0]`==0, `address`>=`ADDR_BASE`, and `(address-ADDR_BASE)>>2` < `DEPTH_WORDS`.
  - Subtraction is 32-bit unsigned; a wrapped result counts as out of range.
- FSM states:
  - IDLE: if exactly one of `read`/`write` is high, latch `address`, `byteenable` and `writedata`, clear the counter, and go to BUSY. When `WAIT_CYCLES`=0, go directly to RESP.
  - IDLE, both `read` and `write` high: protocol error. Set `err`, keep `waitrequest` low, do no memory access, stay in IDLE.
  - BUSY: increment the counter; when counter==`WAIT_CYCLES`-1, go to RESP.
  - On the edge into RESP, read the latched word into the `readdata` register (read) or stage the write.
  - RESP: `waitrequest` low, transfer completes, go to IDLE. A staged write commits on this edge for lanes with `byteenable` set.
- `waitrequest` = (`read`|`write`) AND NOT both AND state != RESP. It is combinational from the request inputs, so it rises in the cycle the request appears.
- Faulting access (out of range or misaligned):
  - Same wait-state timing as a normal access.
  - Read returns 32'h0; write is dropped.
  - `err` is set on the RESP edge.
- Abort: if `read` and `write` both drop while in BUSY, return to IDLE on the next edge. No write commits and `readdata` is unchanged.
- Backdoor:
  - `load_en` writes the full word on the edge, in any state.
  - An out-of-range `load_addr` is ignored and does not set `err`.
  - If a backdoor write and a bus write commit to the same word on the same edge, the backdoor wins.
- Reset:
  - State returns to IDLE, counter to 0, `readdata` to 32'h0, `err` to 0.
  - `waitrequest` is forced to 0 while `rst` is low.
  - Memory contents are preserved through reset.
  - Reset mid-transfer drops any pending write.

## Timing
- Each transfer has `waitrequest` high for exactly `WAIT_CYCLES`+1 cycles (cycle 0 is the one where the request first appears), then low for one cycle. Completion is in cycle `WAIT_CYCLES`+1.
- Back-to-back requests: a new request may be presented in the cycle after completion and starts from IDLE. There is no pipelining and at most one transfer is outstanding.
- Read-after-write to the same word: the read returns the new data, since the write commits before the next request is sampled.
- `readdata` holds its value between transfers.

## Test plan
- Preload: backdoor-load 32'h3C011234 at 32'hBFC00000, release reset, read 32'hBFC00000 with `WAIT_CYCLES`=2. Expect `waitrequest` high for 3 cycles, low in cycle 3, and `readdata`=32'h3C011234.
- Byte-lane write: write 32'hAABBCCDD with `byteenable`=4'b0101 over old word 32'h11223344, then read back. Expect 32'h11BB33DD.
- Faults:
  - Read 32'hBFC00002: returns 0 and `err`=1.
  - After reset, read 32'hBFC00000+4*`DEPTH_WORDS`: returns 0 and `err`=1.
  - Read 32'h00000000: `err`=1 via the wrapped subtraction.
- Abort and dual request:
  - Drop `read` in BUSY: FSM returns to IDLE and `readdata` is unchanged.
  - Assert `read` and `write` together: `waitrequest` stays 0, `err`=1, memory is unchanged.
- Reset mid-write: assert `rst` low during BUSY of a write to word 5. Expect all outputs 0, word 5 unchanged, and earlier preloaded words still readable.
- Zero wait states: with `WAIT_CYCLES`=0, run 8 back-to-back reads. Each read completes in 2 cycles and returns the preloaded values in order.

Source files
------------

// File: rtl/mips_avalon_mem_responder_if.sv
// Avalon-style memory bus between the CPU master and the word memory responder.
interface mips_avalon_mem_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_avalon_mem_responder.sv
// Word memory responder for the CPU's Avalon port: window decode, programmable
// wait states, byte-enabled writes, sticky fault flag and a backdoor preload port.
//
// state | meaning
// IDLE  | no transfer; accepts a single read or write, flags dual requests
// BUSY  | counting wait states for the latched request
// RESP  | waitrequest low; read data presented, staged write commits on exit
module mips_avalon_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mips_avalon_mem_responder_if.slave bus,
  output logic        err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   readdata_q;
  logic [AW-1:0] lat_idx;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic          lat_write;
  logic          lat_ok;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   bus_off;
  logic [31:0]   load_off;
  logic          bus_ok;
  logic          load_ok;
  logic [AW-1:0] bus_idx;
  logic [AW-1:0] load_idx;
  logic          req_one;
  logic          req_both;
  logic          commit;

  // The explicit a >= ADDR_BASE test rejects addresses whose offset wrapped.
  function automatic logic decode_ok(input logic [31:0] a, input logic [31:0] off);
    return (a[1:0] == 2'b00) && (a >= ADDR_BASE) && ((off >> 2) < DEPTH_W);
  endfunction

  always_comb begin
    bus_off  = bus.address - ADDR_BASE;
    load_off = load_addr - ADDR_BASE;
    bus_ok   = decode_ok(bus.address, bus_off);
    load_ok  = decode_ok(load_addr, load_off);
    bus_idx  = bus_off[AW+1:2];
    load_idx = load_off[AW+1:2];
  end

  assign req_one         = bus.read ^ bus.write;
  assign req_both        = bus.read & bus.write;
  assign bus.waitrequest = rst & req_one & (state != S_RESP);
  assign bus.readdata    = readdata_q;
  assign commit          = (state == S_RESP) && lat_write && lat_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      readdata_q <= 32'h0;
      err        <= 1'b0;
      lat_idx    <= '0;
      lat_be     <= 4'h0;
      lat_wdata  <= 32'h0;
      lat_write  <= 1'b0;
      lat_ok     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_both) begin
            err <= 1'b1;
          end else if (req_one) begin
            lat_idx   <= bus_idx;
            lat_be    <= bus.byteenable;
            lat_wdata <= bus.writedata;
            lat_write <= bus.write;
            lat_ok    <= bus_ok;
            cnt       <= 4'd0;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
              if (bus.read) readdata_q <= bus_ok ? mem[bus_idx] : 32'h0;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!(bus.read | bus.write)) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == WAIT_LAST) begin
              state <= S_RESP;
              if (!lat_write) readdata_q <= lat_ok ? mem[lat_idx] : 32'h0;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (!lat_ok) err <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Contents survive reset; the backdoor write is last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
    if (load_en && load_ok) mem[load_idx] <= load_data;
  end
endmodule

// File: tb/tb_mips_avalon_mem_responder.sv
// Scoreboard bench: randomized and directed transfers against a word-array model
// for a 2-wait-state responder and a zero-wait-state responder.
module tb_mips_avalon_mem_responder;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 64;

  typedef logic [31:0] word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  always #5 clk = ~clk;

  logic  load_en = 1'b0;
  word_t load_addr = 32'h0;
  word_t load_data = 32'h0;
  logic  err2, err0;
  logic  sel0 = 1'b0;

  word_t      t_addr = 32'h0;
  word_t      t_wdata = 32'h0;
  logic       t_read = 1'b0;
  logic       t_write = 1'b0;
  logic [3:0] t_be = 4'h0;

  mips_avalon_mem_responder_if bus2();
  mips_avalon_mem_responder_if bus0();

  assign bus2.address    = t_addr;
  assign bus2.writedata  = t_wdata;
  assign bus2.byteenable = t_be;
  assign bus2.read       = t_read & ~sel0;
  assign bus2.write      = t_write & ~sel0;
  assign bus0.address    = t_addr;
  assign bus0.writedata  = t_wdata;
  assign bus0.byteenable = t_be;
  assign bus0.read       = t_read & sel0;
  assign bus0.write      = t_write & sel0;

  logic  wreq, derr;
  word_t rdata;
  assign wreq  = sel0 ? bus0.waitrequest : bus2.waitrequest;
  assign rdata = sel0 ? bus0.readdata : bus2.readdata;
  assign derr  = sel0 ? err0 : err2;

  mips_avalon_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus2), .err(err2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  mips_avalon_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .err(err0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Reference model: plain word arrays keyed by word number within the window.
  word_t ref_mem  [int];
  word_t ref0_mem [int];
  bit    ref_err2 = 1'b0;
  bit    ref_err0 = 1'b0;
  word_t exp_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic bit ref_ok(input word_t a);
    longint la, lb;
    la = {32'h0, a};
    lb = {32'h0, BASE};
    return (la % 4 == 0) && (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  function automatic int key(input word_t a);
    longint la, lb;
    la = {32'h0, a};
    lb = {32'h0, BASE};
    return int'((la - lb) / 4);
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    if (rst && t_read && !t_write && !wreq) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got %h expected no read completion at %0t", rdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("readdata", rdata, e);
      end
    end
  end

  task automatic backdoor(input word_t a, input word_t d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (ref_ok(a)) begin
      ref_mem[key(a)]  = d;
      ref0_mem[key(a)] = d;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after completion so calls chain back-to-back.
  task automatic xfer(input bit wr, input word_t a, input logic [3:0] be, input word_t d);
    int    hi;
    bit    done;
    bit    ok;
    int    w;
    word_t m;
    ok = ref_ok(a);
    w  = sel0 ? 0 : 2;
    if (!wr) begin
      if (!ok) exp_q.push_back(32'h0);
      else if (sel0) exp_q.push_back(ref0_mem[key(a)]);
      else exp_q.push_back(ref_mem[key(a)]);
    end
    t_addr = a; t_read = !wr; t_write = wr; t_be = be; t_wdata = d;
    hi = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wreq) hi++;
      else done = 1'b1;
    end
    chk("wait_cycles", 32'(hi), 32'(w + 1));
    @(posedge clk); #1;
    t_read = 1'b0; t_write = 1'b0;
    if (wr && ok && !sel0) begin
      m = ref_mem[key(a)];
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
      ref_mem[key(a)] = m;
    end
    if (!ok) begin
      if (sel0) ref_err0 = 1'b1;
      else ref_err2 = 1'b1;
    end
    chk("err", 32'(derr), 32'(sel0 ? ref_err0 : ref_err2));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_readdata", rdata, 32'h0);
    chk("rst_err", 32'(derr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    ref_err2 = 1'b0;
    ref_err0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    word_t old5;
    repeat (2) @(posedge clk);
    #1;
    t_addr = BASE; t_read = 1'b1;
    @(negedge clk);
    chk("rst_waitrequest", 32'(wreq), 32'h0);
    chk("rst_readdata", rdata, 32'h0);
    chk("rst_err", 32'(derr), 32'h0);
    @(posedge clk); #1;
    t_read = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) backdoor(BASE, 32'h3C011234);
      else if (i == 1) backdoor(BASE + 32'd4, 32'h11223344);
      else backdoor(BASE + 32'(4 * i), $urandom);
    end
    backdoor(BASE + 32'(4 * DEPTH), 32'hFFFFFFFF);
    rst = 1'b1;
    @(posedge clk); #1;

    xfer(1'b0, BASE, 4'h0, 32'h0);
    xfer(1'b1, BASE + 32'd4, 4'b0101, 32'hAABBCCDD);
    xfer(1'b0, BASE + 32'd4, 4'h0, 32'h0);
    chk("byte_lane_model", ref_mem[1], 32'h11BB33DD);

    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom_range(0, 1)), BASE + 32'(4 * $urandom_range(0, DEPTH - 1)),
           4'($urandom), $urandom);
    end

    xfer(1'b0, 32'hBFC00002, 4'h0, 32'h0);
    do_reset();
    xfer(1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
    do_reset();
    xfer(1'b0, 32'h00000000, 4'h0, 32'h0);
    do_reset();

    t_addr = BASE + 32'd4; t_read = 1'b1; t_write = 1'b1; t_be = 4'hF; t_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("dual_waitrequest", 32'(wreq), 32'h0);
    @(posedge clk); #1;
    t_read = 1'b0; t_write = 1'b0;
    ref_err2 = 1'b1;
    chk("dual_err", 32'(derr), 32'(ref_err2));
    xfer(1'b0, BASE + 32'd4, 4'h0, 32'h0);

    xfer(1'b0, BASE + 32'd8, 4'h0, 32'h0);
    t_addr = BASE + 32'd12; t_read = 1'b1;
    @(negedge clk);
    chk("abort_waitrequest", 32'(wreq), 32'h1);
    @(posedge clk); #1;
    t_read = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_readdata", rdata, ref_mem[2]);
    @(posedge clk); #1;
    xfer(1'b0, BASE + 32'd12, 4'h0, 32'h0);

    old5 = ref_mem[5];
    t_addr = BASE + 32'd20; t_write = 1'b1; t_be = 4'hF; t_wdata = ~old5;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_waitrequest", 32'(wreq), 32'h0);
    chk("midrst_readdata", rdata, 32'h0);
    chk("midrst_err", 32'(derr), 32'h0);
    @(posedge clk); #1;
    t_write = 1'b0;
    rst = 1'b1;
    ref_err2 = 1'b0;
    ref_err0 = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, BASE + 32'd20, 4'h0, 32'h0);
    xfer(1'b0, BASE, 4'h0, 32'h0);

    sel0 = 1'b1;
    for (int i = 0; i < 8; i++) xfer(1'b0, BASE + 32'(4 * i), 4'h0, 32'h0);
    sel0 = 1'b0;
    @(posedge clk); #1;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
